// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types for the programmable-modulus counter family.
//   mode_e  : run mode selected by the 2-bit mode input
//   state_e : ONESHOT sequencing state
//   modeWraps() : true for the modes that roll over at the limit
// -----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // The reserved encoding is treated exactly like WRAP so that a stray
    // mode value never leaves the counter stuck.
    function automatic logic modeWraps(input mode_e m);
        return (m == MODE_WRAP) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides enabled cycles down to one tick every (prescale_i + 1) cycles.
// Ports:
//   clk_i      : rising-edge clock
//   rst_ni     : synchronous active-low reset
//   enable_i   : advance the prescaler this cycle (holds when low)
//   clear_i    : restart the period from zero (wins over enable_i)
//   prescale_i : compare value; 0 gives a tick every enabled cycle
//   tick_o     : combinational, high on the enabled cycle that ends a period
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] preCnt_q;
    logic [PRESCALE_W-1:0] preCnt_d;

    assign tick_o = enable_i && (preCnt_q == prescale_i);

    // Next period position. If prescale is lowered below the current
    // position, the counter simply runs on and wraps before matching again.
    always_comb begin
        preCnt_d = preCnt_q;
        if (clear_i) begin
            preCnt_d = '0;
        end else if (enable_i) begin
            preCnt_d = tick_o ? '0 : preCnt_q + PRESCALE_W'(1);
        end
    end

    // Period register; reset is sampled on the clock edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            preCnt_q <= '0;
        end else begin
            preCnt_q <= preCnt_d;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Up/down counter over 0..modulus with prescaler and WRAP / SATURATE /
// ONESHOT run modes. All outputs are registered.
// Ports:
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   enable_i          : advance prescaler/counter
//   load_i, load_value_i : load count (highest priority after reset)
//   direction_i       : 1 = up, 0 = down
//   mode_i            : 00 WRAP, 01 SATURATE, 10 ONESHOT, 11 as WRAP
//   modulus_i         : upper limit of the count range
//   prescale_i        : one step every prescale_i+1 enabled cycles
//   start_i           : ONESHOT arm request
//   count_o           : current count
//   step_pulse_o      : count changed by a step this cycle
//   tc_o              : terminal-count pulse
//   at_limit_o        : count at the limit for the current direction
//   busy_o            : ONESHOT run in progress
// -----------------------------------------------------------------------------
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      load_value_i,
    input  logic                  direction_i,
    input  logic [1:0]            mode_i,
    input  logic [WIDTH-1:0]      modulus_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  start_i,
    output logic [WIDTH-1:0]      count_o,
    output logic                  step_pulse_o,
    output logic                  tc_o,
    output logic                  at_limit_o,
    output logic                  busy_o
);

    mode_e            mode;
    logic             isOneshot;
    logic             stepQual;
    logic             startAccept;
    logic             tick;

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] count_q,     count_d;
    logic             stepPulse_q, stepPulse_d;
    logic             tc_q,        tc_d;
    logic             atLimit_q,   atLimit_d;
    logic             busy_q,      busy_d;

    logic [WIDTH-1:0] nextVal;
    logic             wrapEvent;
    logic             landsOnLimit;

    assign mode        = mode_e'(mode_i);
    assign isOneshot   = (mode == MODE_ONESHOT);
    // Free-running modes always step; ONESHOT steps only while a run is armed.
    assign stepQual    = !isOneshot || (state_q == ST_RUN);
    // A start is only honoured when not already running, and load outranks it.
    assign startAccept = isOneshot && start_i && (state_q != ST_RUN) && !load_i;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .enable_i   (enable_i && stepQual),
        .clear_i    (load_i || startAccept),
        .prescale_i (prescale_i),
        .tick_o     (tick)
    );

    // Next count, pulses and ONESHOT state. Load beats start, start beats a
    // step. A step first computes the candidate value, then each mode decides
    // what a terminal count means: WRAP flags the rollover itself, SATURATE
    // flags only an actual move onto the limit, ONESHOT flags landing on the
    // limit (even when modulus is 0) and finishes the run.
    always_comb begin
        count_d      = count_q;
        state_d      = state_q;
        stepPulse_d  = 1'b0;
        tc_d         = 1'b0;
        nextVal      = count_q;
        wrapEvent    = 1'b0;
        landsOnLimit = 1'b0;

        if (load_i) begin
            count_d = load_value_i;
            state_d = ST_IDLE;
        end else if (startAccept) begin
            count_d = direction_i ? '0 : modulus_i;
            state_d = ST_RUN;
        end else begin
            if (!isOneshot) begin
                state_d = ST_IDLE;
            end
            if (tick) begin
                if (direction_i) begin
                    wrapEvent = (count_q >= modulus_i);
                    if (!wrapEvent) begin
                        nextVal = count_q + WIDTH'(1);
                    end else begin
                        nextVal = modeWraps(mode) ? '0 : modulus_i;
                    end
                    landsOnLimit = (nextVal == modulus_i);
                end else begin
                    wrapEvent = (count_q == '0);
                    if (!wrapEvent) begin
                        nextVal = count_q - WIDTH'(1);
                    end else begin
                        nextVal = modeWraps(mode) ? modulus_i : '0;
                    end
                    landsOnLimit = (nextVal == '0);
                end

                count_d     = nextVal;
                stepPulse_d = (nextVal != count_q);

                if (modeWraps(mode)) begin
                    tc_d = wrapEvent;
                end else if (mode == MODE_SAT) begin
                    tc_d = stepPulse_d && landsOnLimit;
                end else begin
                    tc_d = landsOnLimit;
                    if (landsOnLimit) begin
                        state_d = ST_DONE;
                    end
                end
            end
        end

        atLimit_d = direction_i ? (count_d >= modulus_i) : (count_d == '0);
        busy_d    = (state_d == ST_RUN);
    end

    // State and output registers. at_limit during reset is evaluated against
    // the zero count that reset produces.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            stepPulse_q <= 1'b0;
            tc_q        <= 1'b0;
            atLimit_q   <= direction_i ? (modulus_i == '0) : 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            stepPulse_q <= stepPulse_d;
            tc_q        <= tc_d;
            atLimit_q   <= atLimit_d;
            busy_q      <= busy_d;
        end
    end

    assign count_o      = count_q;
    assign step_pulse_o = stepPulse_q;
    assign tc_o         = tc_q;
    assign at_limit_o   = atLimit_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
// Drives directed scenarios followed by random traffic into mod_counter.
// Each applied cycle is run through a behavioural model and the expected
// outputs are queued; an independent monitor pops and compares after every
// rising edge.
// -----------------------------------------------------------------------------
module tb_mod_counter;

    localparam int WIDTH = 8;
    localparam int PW    = 4;
    localparam int CMAX  = 1 << WIDTH;
    localparam int PMAX  = 1 << PW;

    typedef struct {
        bit       rstN;
        bit       en;
        bit       load;
        int       loadV;
        bit       dir;
        int       mode;
        int       modulus;
        int       prescale;
        bit       start;
    } stim_t;

    typedef struct {
        int count;
        bit step;
        bit tc;
        bit atLimit;
        bit busy;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstN;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] loadValue;
    logic             direction;
    logic [1:0]       mode;
    logic [WIDTH-1:0] modulus;
    logic [PW-1:0]    prescale;
    logic             start;
    logic [WIDTH-1:0] count;
    logic             stepPulse;
    logic             tc;
    logic             atLimit;
    logic             busy;

    exp_t  expQ[$];
    stim_t cur;
    int    nVectors     = 0;
    int    nMiscompares = 0;

    // Reference model state: plain integers, run phase as a small number.
    int mCount = 0;
    int mPre   = 0;
    int mPhase = 0;   // 0 idle, 1 running, 2 finished

    always #5 clk = ~clk;

    mod_counter #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .enable_i     (enable),
        .load_i       (load),
        .load_value_i (loadValue),
        .direction_i  (direction),
        .mode_i       (mode),
        .modulus_i    (modulus),
        .prescale_i   (prescale),
        .start_i      (start),
        .count_o      (count),
        .step_pulse_o (stepPulse),
        .tc_o         (tc),
        .at_limit_o   (atLimit),
        .busy_o       (busy)
    );

    // Behavioural model of one clock edge: applies the documented rules for
    // reset, load, start, prescaling and each run mode to integer state.
    function automatic exp_t modelEdge(input stim_t s);
        exp_t e;
        bit   tick;
        bit   wraps;
        bit   oneShot;
        int   limit;
        int   nxt;
        e.step  = 0;
        e.tc    = 0;
        wraps   = (s.mode == 0) || (s.mode == 3);
        oneShot = (s.mode == 2);
        if (!s.rstN) begin
            mCount = 0;
            mPre   = 0;
            mPhase = 0;
        end else if (s.load) begin
            mCount = s.loadV;
            mPre   = 0;
            mPhase = 0;
        end else if (oneShot && s.start && mPhase != 1) begin
            mCount = s.dir ? 0 : s.modulus;
            mPre   = 0;
            mPhase = 1;
        end else begin
            tick = 0;
            if (s.en && (!oneShot || mPhase == 1)) begin
                if (mPre == s.prescale) begin
                    tick = 1;
                    mPre = 0;
                end else begin
                    mPre = (mPre + 1) % PMAX;
                end
            end
            if (!oneShot) mPhase = 0;
            if (tick) begin
                limit = s.dir ? s.modulus : 0;
                if (s.dir) begin
                    if (mCount < s.modulus) nxt = mCount + 1;
                    else                    nxt = wraps ? 0 : s.modulus;
                end else begin
                    if (mCount > 0) nxt = mCount - 1;
                    else            nxt = wraps ? s.modulus : 0;
                end
                e.step = (nxt != mCount);
                if (wraps) begin
                    e.tc = s.dir ? (mCount >= s.modulus) : (mCount == 0);
                end else if (!oneShot) begin
                    e.tc = e.step && (nxt == limit);
                end else begin
                    e.tc = (nxt == limit);
                    if (e.tc) mPhase = 2;
                end
                mCount = nxt;
            end
        end
        e.count   = mCount;
        e.atLimit = s.dir ? (mCount >= s.modulus) : (mCount == 0);
        e.busy    = (mPhase == 1);
        return e;
    endfunction

    task automatic driveInputs(input stim_t s);
        rstN      = s.rstN;
        enable    = s.en;
        load      = s.load;
        loadValue = WIDTH'(s.loadV);
        direction = s.dir;
        mode      = 2'(s.mode);
        modulus   = WIDTH'(s.modulus);
        prescale  = PW'(s.prescale);
        start     = s.start;
    endtask

    // Present one cycle of inputs away from the active edge and queue the
    // response the model predicts for the edge that follows.
    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        driveInputs(s);
        expQ.push_back(modelEdge(s));
    endtask

    task automatic compareField(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        if (act !== req) begin
            nMiscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        nVectors++;
        compareField("count",      32'(count),     32'(e.count));
        compareField("step_pulse", 32'(stepPulse), 32'(e.step));
        compareField("tc",         32'(tc),        32'(e.tc));
        compareField("at_limit",   32'(atLimit),   32'(e.atLimit));
        compareField("busy",       32'(busy),      32'(e.busy));
    endtask

    // Monitor: after each rising edge, settle, then check the oldest
    // outstanding expectation against what the DUT presents.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(cur);
    endtask

    task automatic pulseLoad(input int v);
        cur.load  = 1;
        cur.loadV = v;
        applyStimulus(cur);
        cur.load  = 0;
    endtask

    task automatic pulseStart();
        cur.start = 1;
        applyStimulus(cur);
        cur.start = 0;
    endtask

    task automatic pulseReset();
        cur.rstN = 0;
        applyStimulus(cur);
        cur.rstN = 1;
    endtask

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        int drain;
        cur.rstN = 0; cur.en = 1; cur.load = 0; cur.loadV = 0; cur.dir = 1;
        cur.mode = 0; cur.modulus = 5; cur.prescale = 0; cur.start = 0;
        driveInputs(cur);

        $display("[TB] reset and initial counting");
        runCycles(2);
        cur.rstN = 1;
        pulseLoad(7);
        runCycles(3);
        cur.dir = 0;
        pulseReset();
        runCycles(1);

        $display("[TB] WRAP up, modulus 5, prescale 0");
        cur.dir = 1; cur.mode = 0; cur.modulus = 5; cur.prescale = 0;
        pulseLoad(0);
        runCycles(9);

        $display("[TB] SATURATE down from 3, prescale 2");
        cur.dir = 0; cur.mode = 1; cur.prescale = 2;
        pulseLoad(3);
        runCycles(16);

        $display("[TB] ONESHOT up, modulus 4, restart");
        cur.dir = 1; cur.mode = 2; cur.modulus = 4; cur.prescale = 0;
        pulseLoad(0);
        runCycles(2);
        pulseStart();
        runCycles(3);
        pulseStart();
        runCycles(4);
        pulseStart();
        runCycles(7);

        $display("[TB] load colliding with a tick");
        cur.mode = 0; cur.modulus = 5; cur.prescale = 0;
        runCycles(3);
        pulseLoad(9);
        runCycles(3);

        $display("[TB] enable dropped mid-period, prescale 3");
        cur.modulus = 10; cur.prescale = 3;
        pulseLoad(0);
        runCycles(2);
        cur.en = 0;
        runCycles(3);
        cur.en = 1;
        runCycles(6);

        $display("[TB] modulus 0 in WRAP and ONESHOT");
        cur.modulus = 0; cur.prescale = 0;
        runCycles(3);
        cur.dir = 0;
        runCycles(3);
        cur.mode = 2; cur.dir = 1;
        pulseStart();
        runCycles(3);

        $display("[TB] reset during a ONESHOT run");
        cur.modulus = 20; cur.prescale = 1;
        pulseStart();
        runCycles(5);
        pulseReset();
        runCycles(3);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            cur.rstN  = ($urandom_range(99) >= 2);
            cur.en    = ($urandom_range(99) < 80);
            cur.load  = ($urandom_range(99) < 4);
            cur.loadV = $urandom_range(CMAX - 1);
            cur.start = ($urandom_range(99) < 10);
            if ($urandom_range(99) < 5) cur.dir = $urandom_range(1);
            if ($urandom_range(99) < 3) cur.mode = $urandom_range(3);
            if ($urandom_range(99) < 3) begin
                if ($urandom_range(9) == 0) cur.modulus = $urandom_range(CMAX - 1);
                else                        cur.modulus = $urandom_range(12);
            end
            if ($urandom_range(99) < 3) begin
                if ($urandom_range(9) == 0) cur.prescale = $urandom_range(PMAX - 1);
                else                        cur.prescale = $urandom_range(3);
            end
            applyStimulus(cur);
        end
        cur.load = 0; cur.start = 0; cur.rstN = 1;

        drain = 0;
        while (expQ.size() > 0 && drain < 10) begin
            @(posedge clk);
            #2;
            drain++;
        end
        if (expQ.size() > 0) begin
            nMiscompares++;
            $display("[TB] FAIL drain: got %0d outstanding, expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
